// File: rtl/cpu_pkg.sv
// Shared definitions for the boot loader that feeds the single-cycle CPU.
//   loader_state_t : loader sequencing states
//   SP_REG_IDX     : register index written by the $sp init pulse
//   HDR_*_WORD     : word offsets inside an image header
package cpu_pkg;

  typedef enum logic [2:0] {
    I_PC,
    I_CNT,
    I_DATA,
    D_SP,
    D_CNT,
    D_DATA,
    D_ZERO,
    DONE
  } loader_state_t;

  localparam int unsigned SP_REG_IDX     = 29;
  localparam int unsigned HDR_INIT_WORD  = 0;
  localparam int unsigned HDR_COUNT_WORD = 1;

endpackage

// File: rtl/image_word_writer.sv
// Word counter plus address generator for one memory image.
//   clk_i, rst_i : clock, synchronous active-high reset
//   start_i      : latch base_i/count_i and clear the word index
//   take_i       : a payload word (wdata_i) was accepted this cycle
//   fill_i       : write a zero word at the current address
//   suppress_i   : accepted payload words produce no strobe
//   we_o/addr_o/wdata_o : registered word write, one cycle per word
//   oor_o        : current address (base + 4k) is outside [0, LIMIT)
//   last_o       : current word is the final one of the image
module image_word_writer #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] base_i,
  input  logic [31:0] count_i,
  input  logic        take_i,
  input  logic        fill_i,
  input  logic        suppress_i,
  input  logic [31:0] wdata_i,
  output logic        we_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  output logic        oor_o,
  output logic        last_o
);

  logic [31:0] base_q;
  logic [31:0] count_q;
  logic [31:0] k_q;
  logic [34:0] addr_ext;

  // Extended sum keeps the carry, so a 32-bit wrap reads as out of range.
  always_comb begin
    addr_ext = {3'b000, base_q} + {1'b0, k_q, 2'b00};
  end

  assign oor_o  = (addr_ext + 35'd3) >= 35'(LIMIT);
  assign last_o = (k_q + 32'd1) == count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q  <= '0;
      count_q <= '0;
      k_q     <= '0;
      we_o    <= 1'b0;
      addr_o  <= '0;
      wdata_o <= '0;
    end else begin
      we_o <= 1'b0;
      if (start_i) begin
        base_q  <= base_i;
        count_q <= count_i;
        k_q     <= '0;
      end else if (take_i) begin
        we_o    <= !oor_o && !suppress_i;
        addr_o  <= addr_ext[31:0];
        wdata_o <= wdata_i;
        k_q     <= k_q + 32'd1;
      end else if (fill_i) begin
        we_o    <= !oor_o;
        addr_o  <= addr_ext[31:0];
        wdata_o <= '0;
        k_q     <= k_q + 32'd1;
      end
    end
  end

endmodule

// File: rtl/image_loader.sv
// Boot loader: consumes the instruction image then the data image from one
// valid/ready word stream, writes them to memory, zero-fills the rest of
// data memory, loads PC and $sp, then releases the CPU.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   word_i/word_valid_i     : stream input; word_ready_o accepts it
//   imem_we_o/addr/wdata    : instruction memory word write
//   dmem_we_o/addr/wdata    : data memory word write
//   pc_load_o/pc_init_o     : one-cycle PC load pulse and value
//   sp_we_o/sp_init_o       : one-cycle $sp write pulse and value
//   cpu_run_o               : CPU active-low reset, 1 once loading is done
//   err_o                   : sticky error (misaligned PC, out-of-range word)
module image_loader
  import cpu_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = 1024,
  parameter int unsigned DMEM_BYTES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] word_i,
  input  logic        word_valid_i,
  output logic        word_ready_o,
  output logic        imem_we_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_wdata_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic        pc_load_o,
  output logic [31:0] pc_init_o,
  output logic        sp_we_o,
  output logic [31:0] sp_init_o,
  output logic        cpu_run_o,
  output logic        err_o
);

  loader_state_t state_q, state_n;

  logic xfer;
  logic i_misaligned;
  logic i_start, i_take, i_oor, i_last;
  logic d_start, d_take, d_fill, d_oor, d_last;
  logic err_set;

  assign xfer    = word_valid_i && word_ready_o;
  assign i_start = xfer && (state_q == I_CNT);
  assign i_take  = xfer && (state_q == I_DATA);
  assign d_start = xfer && (state_q == D_CNT);
  assign d_take  = xfer && (state_q == D_DATA);
  // The data writer's index is already 4m after the payload (0 for m == 0),
  // so zero-fill simply keeps stepping it until it leaves the memory.
  assign d_fill  = (state_q == D_ZERO) && !d_oor;

  assign err_set = (xfer && (state_q == I_PC) && (word_i[1:0] != 2'b00))
                || (i_take && i_oor)
                || (d_take && d_oor);

  image_word_writer #(.LIMIT(IMEM_BYTES)) u_imem_writer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (i_start),
    .base_i     (pc_init_o),
    .count_i    (word_i),
    .take_i     (i_take),
    .fill_i     (1'b0),
    .suppress_i (i_misaligned),
    .wdata_i    (word_i),
    .we_o       (imem_we_o),
    .addr_o     (imem_addr_o),
    .wdata_o    (imem_wdata_o),
    .oor_o      (i_oor),
    .last_o     (i_last)
  );

  image_word_writer #(.LIMIT(DMEM_BYTES)) u_dmem_writer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (d_start),
    .base_i     ('0),
    .count_i    (word_i),
    .take_i     (d_take),
    .fill_i     (d_fill),
    .suppress_i (1'b0),
    .wdata_i    (word_i),
    .we_o       (dmem_we_o),
    .addr_o     (dmem_addr_o),
    .wdata_o    (dmem_wdata_o),
    .oor_o      (d_oor),
    .last_o     (d_last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= I_PC;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      I_PC:    if (xfer) state_n = I_CNT;
      I_CNT:   if (xfer) state_n = (word_i == '0) ? D_SP : I_DATA;
      I_DATA:  if (xfer && i_last) state_n = D_SP;
      D_SP:    if (xfer) state_n = D_CNT;
      D_CNT:   if (xfer) state_n = (word_i == '0) ? D_ZERO : D_DATA;
      D_DATA:  if (xfer && d_last) state_n = D_ZERO;
      D_ZERO:  if (d_oor) state_n = DONE;
      DONE:    state_n = DONE;
      default: state_n = I_PC;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_ready_o <= 1'b0;
      cpu_run_o    <= 1'b0;
      pc_load_o    <= 1'b0;
      pc_init_o    <= '0;
      sp_we_o      <= 1'b0;
      sp_init_o    <= '0;
      err_o        <= 1'b0;
      i_misaligned <= 1'b0;
    end else begin
      // Ready follows the state being entered so it is valid in that state.
      word_ready_o <= (state_n != D_ZERO) && (state_n != DONE);
      cpu_run_o    <= (state_n == DONE);
      pc_load_o    <= 1'b0;
      sp_we_o      <= 1'b0;
      if (xfer && (state_q == I_PC)) begin
        pc_load_o    <= 1'b1;
        pc_init_o    <= word_i;
        i_misaligned <= (word_i[1:0] != 2'b00);
      end
      if (xfer && (state_q == D_SP)) begin
        sp_we_o   <= 1'b1;
        sp_init_o <= word_i;
      end
      if (err_set) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_image_loader.sv
module tb_image_loader;

  logic        clk;
  logic        rst;
  logic [31:0] word;
  logic        word_valid;
  logic        word_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        pc_load;
  logic [31:0] pc_init;
  logic        sp_we;
  logic [31:0] sp_init;
  logic        cpu_run;
  logic        err;

  int checks = 0;
  int errors = 0;

  image_loader #(.IMEM_BYTES(1024), .DMEM_BYTES(1024)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .word_i       (word),
    .word_valid_i (word_valid),
    .word_ready_o (word_ready),
    .imem_we_o    (imem_we),
    .imem_addr_o  (imem_addr),
    .imem_wdata_o (imem_wdata),
    .dmem_we_o    (dmem_we),
    .dmem_addr_o  (dmem_addr),
    .dmem_wdata_o (dmem_wdata),
    .pc_load_o    (pc_load),
    .pc_init_o    (pc_init),
    .sp_we_o      (sp_we),
    .sp_init_o    (sp_init),
    .cpu_run_o    (cpu_run),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write/pulse logs, sampled 2ns after each rising edge.
  logic [31:0] ia[$];
  logic [31:0] id[$];
  logic [31:0] da[$];
  logic [31:0] dd[$];
  int          cyc = 0;
  int          last_dw_cyc = 0;
  int          run_cyc = 0;
  int          pc_cnt = 0;
  int          sp_cnt = 0;
  logic [31:0] pc_seen = '0;
  logic [31:0] sp_seen = '0;

  always @(posedge clk) begin
    #2;
    cyc = cyc + 1;
    if (imem_we) begin ia.push_back(imem_addr); id.push_back(imem_wdata); end
    if (dmem_we) begin da.push_back(dmem_addr); dd.push_back(dmem_wdata); last_dw_cyc = cyc; end
    if (pc_load) begin pc_cnt = pc_cnt + 1; pc_seen = pc_init; end
    if (sp_we)   begin sp_cnt = sp_cnt + 1; sp_seen = sp_init; end
    if (cpu_run && run_cyc == 0) run_cyc = cyc;
  end

  function automatic void clear_logs();
    ia.delete(); id.delete(); da.delete(); dd.delete();
    last_dw_cyc = 0; run_cyc = 0; pc_cnt = 0; sp_cnt = 0;
    pc_seen = '0; sp_seen = '0;
  endfunction

  // Expected dmem log: 256 writes at 4i; first ndata carry d0, rest zero.
  function automatic int dmem_bad(input int ndata, input logic [31:0] d0);
    int bad = 0;
    if (da.size() != 256 || dd.size() != 256) return 1000;
    for (int i = 0; i < 256; i++) begin
      if (da[i] !== 32'(i * 4)) bad++;
      if (dd[i] !== ((i < ndata) ? d0 : 32'h0)) bad++;
    end
    return bad;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic send_word(input logic [31:0] w);
    int t = 0;
    word = w;
    word_valid = 1'b1;
    while (!word_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout: word %h not accepted within 200 cycles", w);
    end else begin
      @(negedge clk);
    end
    word_valid = 1'b0;
  endtask

  task automatic wait_run(input string name);
    int t = 0;
    while (!cpu_run && t < 2000) begin @(negedge clk); t++; end
    checks++;
    if (!cpu_run) begin
      errors++;
      $display("FAIL %s_run_timeout: cpu_run=%b, required 1 within 2000 cycles", name, cpu_run);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic send_basic();
    send_word(32'h0000_0010); send_word(32'd2);
    send_word(32'h2008_0005); send_word(32'hFFFF_FFFF);
    send_word(32'h0000_0400); send_word(32'd1);
    send_word(32'hDEAD_BEEF);
  endtask

  task automatic test_reset();
    logic [31:0] agg;
    word = '0; word_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    agg = imem_addr | imem_wdata | dmem_addr | dmem_wdata | pc_init | sp_init;
    checks++;
    if ({imem_we, dmem_we, pc_load, sp_we, word_ready, cpu_run, err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: we/we/pc/sp/rdy/run/err=%b, required 0000000",
               {imem_we, dmem_we, pc_load, sp_we, word_ready, cpu_run, err});
    end
    checks++;
    if (agg !== 32'h0) begin errors++; $display("FAIL reset_data: OR of addr/data/init=%h, required 0", agg); end
    rst = 1'b0;
    clear_logs();
    @(negedge clk);
    checks++;
    if (word_ready !== 1'b1 || cpu_run !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: ready=%b run=%b, required ready=1 run=0", word_ready, cpu_run);
    end
  endtask

  task automatic test_basic();
    int na, nd;
    do_reset();
    send_basic();
    wait_run("basic");
    checks++;
    if (pc_cnt != 1 || pc_seen !== 32'h10) begin
      errors++; $display("FAIL basic_pc: pulses=%0d pc=%h, required 1 and 00000010", pc_cnt, pc_seen);
    end
    checks++;
    if (ia.size() != 2) begin
      errors++; $display("FAIL basic_imem_count: %0d writes, required 2", ia.size());
    end else begin
      checks++;
      if (ia[0] !== 32'h10 || id[0] !== 32'h2008_0005 || ia[1] !== 32'h14 || id[1] !== 32'hFFFF_FFFF) begin
        errors++;
        $display("FAIL basic_imem_data: %h:%h %h:%h, required 00000010:20080005 00000014:ffffffff",
                 ia[0], id[0], ia[1], id[1]);
      end
    end
    checks++;
    if (sp_cnt != 1 || sp_seen !== 32'h400) begin
      errors++; $display("FAIL basic_sp: pulses=%0d sp=%h, required 1 and 00000400", sp_cnt, sp_seen);
    end
    checks++;
    if (dmem_bad(1, 32'hDEAD_BEEF) != 0) begin
      errors++; $display("FAIL basic_dmem: %0d writes, %0d bad entries, required 256 writes 0 bad",
                         da.size(), dmem_bad(1, 32'hDEAD_BEEF));
    end
    checks++;
    if (run_cyc != last_dw_cyc + 1) begin
      errors++; $display("FAIL basic_run_timing: run at cycle %0d, required %0d", run_cyc, last_dw_cyc + 1);
    end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL basic_err: err=%b, required 0", err); end
    // Words offered in DONE must be ignored.
    na = ia.size(); nd = da.size();
    word = 32'h1234_5678; word_valid = 1'b1;
    repeat (4) @(negedge clk);
    word_valid = 1'b0;
    checks++;
    if (word_ready !== 1'b0 || cpu_run !== 1'b1 || ia.size() != na || da.size() != nd) begin
      errors++;
      $display("FAIL done_ignore: ready=%b run=%b new writes i=%0d d=%0d, required 0 1 0 0",
               word_ready, cpu_run, ia.size() - na, da.size() - nd);
    end
  endtask

  task automatic test_empty();
    do_reset();
    send_word(32'h0); send_word(32'd0);
    send_word(32'h200); send_word(32'd0);
    wait_run("empty");
    checks++;
    if (ia.size() != 0) begin errors++; $display("FAIL empty_imem: %0d writes, required 0", ia.size()); end
    checks++;
    if (dmem_bad(0, 32'h0) != 0) begin
      errors++; $display("FAIL empty_dmem: %0d writes, required 256 zero writes 0x0..0x3fc", da.size());
    end
    checks++;
    if (err !== 1'b0 || sp_seen !== 32'h200) begin
      errors++; $display("FAIL empty_err_sp: err=%b sp=%h, required 0 and 00000200", err, sp_seen);
    end
  endtask

  task automatic test_imem_overflow();
    do_reset();
    send_word(32'h3FC); send_word(32'd2);
    send_word(32'hAAAA_0001); send_word(32'hBBBB_0002);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL ovf_err_early: err=%b, required 1", err); end
    send_word(32'h100); send_word(32'd0);
    wait_run("ovf");
    checks++;
    if (ia.size() != 1) begin
      errors++; $display("FAIL ovf_imem_count: %0d writes, required 1", ia.size());
    end else begin
      checks++;
      if (ia[0] !== 32'h3FC || id[0] !== 32'hAAAA_0001) begin
        errors++; $display("FAIL ovf_imem_data: %h:%h, required 000003fc:aaaa0001", ia[0], id[0]);
      end
    end
    repeat (5) @(negedge clk);
    checks++;
    if (err !== 1'b1 || cpu_run !== 1'b1 || da.size() != 256) begin
      errors++; $display("FAIL ovf_final: err=%b run=%b dwrites=%0d, required 1 1 256", err, cpu_run, da.size());
    end
  endtask

  task automatic test_stall();
    int n0;
    int gap_we = 0;
    do_reset();
    send_word(32'h100); send_word(32'd4);
    send_word(32'hC000_0000); send_word(32'hC000_0001);
    @(negedge clk);
    n0 = ia.size();
    for (int i = 0; i < 5; i++) begin
      if (imem_we || dmem_we || pc_load || sp_we) gap_we++;
      @(negedge clk);
    end
    checks++;
    if (gap_we != 0 || ia.size() != n0 || pc_init !== 32'h100 || word_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_gap: strobes=%0d new writes=%0d pc=%h ready=%b, required 0 0 00000100 1",
               gap_we, ia.size() - n0, pc_init, word_ready);
    end
    send_word(32'hC000_0002); send_word(32'hC000_0003);
    send_word(32'h0); send_word(32'd0);
    wait_run("stall");
    checks++;
    if (ia.size() != 4) begin
      errors++; $display("FAIL stall_count: %0d writes, required 4", ia.size());
    end else begin
      int bad = 0;
      for (int i = 0; i < 4; i++) begin
        if (ia[i] !== 32'(32'h100 + 4 * i) || id[i] !== 32'(32'hC000_0000 + i)) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL stall_addr: %0d bad writes, required 0 (0x100..0x10c)", bad); end
    end
  endtask

  task automatic test_reset_in_zero();
    logic [31:0] agg;
    int t = 0;
    do_reset();
    send_word(32'h0); send_word(32'd0);
    send_word(32'h0); send_word(32'd0);
    while (da.size() < 10 && t < 200) begin @(negedge clk); t++; end
    checks++;
    if (da.size() < 10) begin errors++; $display("FAIL rz_fill_start: %0d writes, required >= 10", da.size()); end
    rst = 1'b1;
    @(negedge clk);
    agg = imem_addr | imem_wdata | dmem_addr | dmem_wdata | pc_init | sp_init;
    checks++;
    if ({imem_we, dmem_we, pc_load, sp_we, word_ready, cpu_run, err} !== 7'b0 || agg !== 32'h0) begin
      errors++;
      $display("FAIL rz_outputs: ctrl=%b data_or=%h, required 0000000 and 0",
               {imem_we, dmem_we, pc_load, sp_we, word_ready, cpu_run, err}, agg);
    end
    rst = 1'b0;
    clear_logs();
    send_basic();
    wait_run("rz_reload");
    checks++;
    if (ia.size() != 2 || pc_seen !== 32'h10 || err !== 1'b0 || dmem_bad(1, 32'hDEAD_BEEF) != 0) begin
      errors++;
      $display("FAIL rz_reload: iwrites=%0d pc=%h err=%b dwrites=%0d, required 2 00000010 0 256",
               ia.size(), pc_seen, err, da.size());
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    send_word(32'h0000_0002); send_word(32'd2);
    send_word(32'h1111_1111); send_word(32'h2222_2222);
    send_word(32'h300); send_word(32'd1);
    send_word(32'h1234_5678);
    wait_run("mis");
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL mis_err: err=%b, required 1", err); end
    checks++;
    if (ia.size() != 0) begin errors++; $display("FAIL mis_imem: %0d writes, required 0", ia.size()); end
    checks++;
    if (pc_seen !== 32'h2 || dmem_bad(1, 32'h1234_5678) != 0 || cpu_run !== 1'b1) begin
      errors++;
      $display("FAIL mis_dimage: pc=%h dwrites=%0d run=%b, required 00000002 256 1", pc_seen, da.size(), cpu_run);
    end
  endtask

  initial begin
    rst = 1'b1;
    word = '0;
    word_valid = 1'b0;
    test_reset();
    test_basic();
    test_empty();
    test_imem_overflow();
    test_stall();
    test_reset_in_zero();
    test_misaligned();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
